alu_arbiter: RTL

- Shares one combinational `alu` instance (XLEN datapath, funct3 `op`, `sign` bit) between NREQ requesters, e.g. the integer execute path and the branch/AGU path.
- Arbitrates round-robin and registers the result in a one-entry output stage.
- Returns the result to the granted requester over a valid/ready handshake.
- Sustains one operation per cycle when responses are consumed promptly.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu.sv | 28 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/alu_arbiter.sv | 62 ++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcode, request type and default datapath width.
package alu_pkg;
  localparam int DEF_XLEN = 32;
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SLL  = 3'b001,
    OP_SLT  = 3'b010,
    OP_SLTU = 3'b011,
    OP_XOR  = 3'b100,
    OP_SR   = 3'b101,
    OP_OR   = 3'b110,
    OP_AND  = 3'b111
  } alu_op_t;
  typedef struct packed {
    logic [DEF_XLEN-1:0] a;
    logic [DEF_XLEN-1:0] b;
    alu_op_t             op;
    logic                sign;
  } alu_req_t;
endpackage

// File: rtl/alu.sv
// alu: combinational integer ALU; sign selects SUB for ADD and arithmetic shift for SR.
module alu import alu_pkg::*; #(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  input  logic            sign,
  output logic [XLEN-1:0] y
);
  localparam int SHW = $clog2(XLEN);
  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];
  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = sign ? a - b : a + b;
      OP_SLL:  y = a << shamt;
      OP_SLT:  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: y = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  y = a ^ b;
      OP_SR:   y = sign ? XLEN'($signed(a) >>> shamt) : a >> shamt;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      default: y = '0;
    endcase
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, searching from last+1 with wrap.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] grant
);
  logic [IDW:0]   sum  [NREQ];
  logic [IDW-1:0] cand [NREQ];
  logic           found;
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum[k]  = {1'b0, last} + (IDW+1)'(k + 1);
      cand[k] = sum[k] >= (IDW+1)'(NREQ) ? IDW'(sum[k] - (IDW+1)'(NREQ)) : sum[k][IDW-1:0];
      if (!found && req[cand[k]]) begin
        grant[cand[k]] = 1'b1;
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NREQ requesters with a one-entry result stage.
module alu_arbiter import alu_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  input  logic [NREQ*3-1:0]    req_op,
  input  logic [NREQ-1:0]      req_sign,
  output logic [NREQ-1:0]      resp_valid,
  input  logic [NREQ-1:0]      resp_ready,
  output logic [XLEN-1:0]      resp_result
);
  localparam int IDW = $clog2(NREQ);
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  g, rr_last, out_id;
  logic [XLEN-1:0] a_sel, b_sel, alu_y, out_result;
  logic [2:0]      op_sel;
  logic            sign_sel, out_valid, can_accept, accept;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(req_valid), .last(rr_last), .grant(grant));
  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    op_sel   = '0;
    sign_sel = 1'b0;
    g        = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel    |= grant[i] ? req_a[i*XLEN +: XLEN] : '0;
      b_sel    |= grant[i] ? req_b[i*XLEN +: XLEN] : '0;
      op_sel   |= grant[i] ? req_op[i*3 +: 3] : 3'b000;
      sign_sel |= grant[i] & req_sign[i];
      g        |= grant[i] ? IDW'(i) : '0;
    end
  end
  alu #(.XLEN(XLEN)) u_alu (.a(a_sel), .b(b_sel), .op(alu_op_t'(op_sel)), .sign(sign_sel), .y(alu_y));
  assign can_accept  = !flush && (!out_valid || resp_ready[out_id]);
  assign req_ready   = can_accept ? grant : '0;
  assign accept      = can_accept && |grant;
  assign resp_valid  = out_valid ? {{(NREQ-1){1'b0}}, 1'b1} << out_id : '0;
  assign resp_result = out_result;
  // An accept overwrites a draining entry in place, so back-to-back ops leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_id     <= '0;
      out_result <= '0;
      rr_last    <= IDW'(NREQ - 1);
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_id     <= g;
      out_result <= alu_y;
      rr_last    <= g;
    end else if (flush || (out_valid && resp_ready[out_id])) begin
      out_valid  <= 1'b0;
    end
  end
endmodule
